// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: function codes, widths,
// error flag encodings and the arbiter FSM state type.
package mem_port_arbiter_pkg;

  // Default widths of the memory_unit interface.
  localparam int MEMORY_ADDR_WIDTH = 10;
  localparam int MEMORY_DATA_WIDTH = 64;

  // memory_unit function codes.
  localparam logic [1:0] GET_CONTENTS = 2'b01;
  localparam logic [1:0] SET_CONTENTS = 2'b10;

  // Sticky error flags reported on err.
  localparam logic [7:0] ARB_ERR_TIMEOUT = 8'h01;
  localparam logic [7:0] ARB_ERR_OVERRUN = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_req_slot.sv
// One pending-request slot: a pending flag plus the func/addr/wdata captured
// with the request strobe. The captured fields stay valid after the flag
// clears, so the arbiter can copy them in the same cycle it takes the grant.
//  clk, rst      clock, asynchronous active-low reset
//  capture_i     accept a new request (sets pending, captures fields)
//  clear_i       grant taken (clears pending)
//  func_i/addr_i/wdat_i   request fields to capture
//  pend_o        request pending
//  func_o/addr_o/wdat_o   captured request fields
module arb_req_slot #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [1:0]        func_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdat_i,
  output logic              pend_o,
  output logic [1:0]        func_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdat_o
);

  logic              pend_q, pend_d;
  logic [1:0]        func_q, func_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  // Capture and clear cannot coincide: capture needs the slot empty,
  // clear needs it full.
  always_comb begin
    pend_d = pend_q;
    func_d = func_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    if (capture_i) begin
      pend_d = 1'b1;
      func_d = func_i;
      addr_d = addr_i;
      wdat_d = wdat_i;
    end else if (clear_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      func_q <= '0;
      addr_q <= '0;
      wdat_q <= '0;
    end else begin
      pend_q <= pend_d;
      func_q <= func_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
    end
  end

  assign pend_o = pend_q;
  assign func_o = func_q;
  assign addr_o = addr_q;
  assign wdat_o = wdat_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory_unit port between the traversal engine
// (requester 0) and the execute unit (requester 1). Single-cycle requests are
// latched into pending slots, granted one at a time (round-robin, with lock
// holding off requester 0), issued to memory_unit with a one-cycle
// m_execute, and completed with a one-cycle done pulse to the owner.
//  clk, rst                 clock, asynchronous active-low reset
//  lock                     execute unit owns the port; req 0 stays pending
//  req0/1, func0/1, addr0/1, wdat0/1   request strobes and fields
//  done0/1, rdata           completion pulse and read data to the owner
//  m_execute, m_func, m_addr, m_wdata, m_ready, m_rdata   memory_unit side
//  busy                     transaction in flight
//  err                      sticky error flags (timeout, overrun)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEMORY_ADDR_WIDTH,
  parameter int DATA_W  = MEMORY_DATA_WIDTH,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        func0,
  input  logic [1:0]        func1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdat0,
  input  logic [DATA_W-1:0] wdat1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              m_execute,
  output logic [1:0]        m_func,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic [7:0]        err
);

  // Last WAIT count before the timeout fires; WAIT lasts TMO_CYC cycles.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        m_func_q, m_func_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        err_q, err_d;

  logic [1:0]        req_v;
  logic [1:0]        accept;
  logic [1:0]        clear;
  logic [1:0]        pend;
  logic [1:0]        elig;
  logic              grant_valid;
  logic              grant_sel;

  logic [1:0]        req_func [2];
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_wdat [2];
  logic [1:0]        slot_func [2];
  logic [ADDR_W-1:0] slot_addr [2];
  logic [DATA_W-1:0] slot_wdat [2];

  assign req_v       = {req1, req0};
  assign req_func[0] = func0;
  assign req_func[1] = func1;
  assign req_addr[0] = addr0;
  assign req_addr[1] = addr1;
  assign req_wdat[0] = wdat0;
  assign req_wdat[1] = wdat1;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    // A request is dropped while its own slot is full or while its own
    // transaction is still in flight (including the done cycle).
    assign accept[gi] = req_v[gi] && !pend[gi] &&
                        !((state_q != ST_IDLE) && (owner_q == 1'(gi)));
    assign clear[gi]  = grant_valid && (grant_sel == 1'(gi));

    arb_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .capture_i (accept[gi]),
      .clear_i   (clear[gi]),
      .func_i    (req_func[gi]),
      .addr_i    (req_addr[gi]),
      .wdat_i    (req_wdat[gi]),
      .pend_o    (pend[gi]),
      .func_o    (slot_func[gi]),
      .addr_o    (slot_addr[gi]),
      .wdat_o    (slot_wdat[gi])
    );
  end

  // Grant selection: lock makes requester 0 ineligible; with both eligible
  // the one that was not served last wins.
  always_comb begin
    elig      = {pend[1], pend[0] & ~lock};
    grant_sel = 1'b0;
    if (elig == 2'b11) begin
      grant_sel = ~last_grant_q;
    end else if (elig[1]) begin
      grant_sel = 1'b1;
    end
    grant_valid = (state_q == ST_IDLE) && (elig != 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_func_d     = m_func_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    if ((req_v & ~accept) != 2'b00) begin
      err_d = err_d | ARB_ERR_OVERRUN;
    end
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d   = grant_sel;
          m_func_d  = slot_func[grant_sel];
          m_addr_d  = slot_addr[grant_sel];
          m_wdata_d = slot_wdat[grant_sel];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_ready) begin
          rdata_d = m_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          // Complete anyway so the requester is not stranded; rdata keeps
          // its previous value.
          err_d   = err_d | ARB_ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        last_grant_d = owner_q;
        cnt_d        = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      m_func_q     <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      rdata_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_func_q     <= m_func_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign m_execute = (state_q == ST_ISSUE);
  assign done0     = (state_q == ST_RESP) && !owner_q;
  assign done1     = (state_q == ST_RESP) && owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign m_func    = m_func_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic        req0, req1;
  logic [1:0]  func0, func1;
  logic [9:0]  addr0, addr1;
  logic [63:0] wdat0, wdat1;
  logic        done0, done1;
  logic [63:0] rdata;
  logic        m_execute;
  logic [1:0]  m_func;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_rdata;
  logic        busy;
  logic [7:0]  err;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .TMO_CYC(255)) dut (
    .clk(clk), .rst(rst), .lock(lock),
    .req0(req0), .req1(req1), .func0(func0), .func1(func1),
    .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
    .done0(done0), .done1(done1), .rdata(rdata),
    .m_execute(m_execute), .m_func(m_func), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cyc  = 0;

  // Memory responder model
  int          countdown = 0;
  int          mem_lat   = 3;
  bit          mem_en    = 1'b1;
  logic [63:0] rd_base   = '0;

  // Observation logs
  logic [9:0]  exec_addr_q[$];
  logic [1:0]  exec_func_q[$];
  logic [63:0] exec_wdat_q[$];
  int          exec_cyc_q[$];
  int          done_own_q[$];
  int          done_cyc_q[$];

  typedef struct {
    bit          lock;
    bit          r0;
    bit          r1;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [63:0] w0;
    logic [63:0] w1;
    int          lat;
    logic [63:0] base;
    int          e_nexec;
    logic [9:0]  e_addr;
    logic [1:0]  e_func;
    logic [63:0] e_wdat;
    int          e_owner;
    int          e_d0;
    int          e_d1;
    logic [63:0] e_rdata;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_owner(input int o);
    int n = 0;
    foreach (done_own_q[i]) if (done_own_q[i] == o) n++;
    return n;
  endfunction

  // Advance one cycle; observe outputs 1 time unit after the edge and
  // drive the memory responder for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    m_ready = 1'b0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0 && mem_en) begin
        m_ready = 1'b1;
        m_rdata = rd_base + 64'(m_addr);
      end
    end
    if (m_execute) begin
      exec_addr_q.push_back(m_addr);
      exec_func_q.push_back(m_func);
      exec_wdat_q.push_back(m_wdata);
      exec_cyc_q.push_back(cyc);
      countdown = mem_lat;
    end
    if (done0) begin
      done_own_q.push_back(0);
      done_cyc_q.push_back(cyc);
    end
    if (done1) begin
      done_own_q.push_back(1);
      done_cyc_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    exec_addr_q.delete();
    exec_func_q.delete();
    exec_wdat_q.delete();
    exec_cyc_q.delete();
    done_own_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock = 1'b0;
    m_ready = 1'b0; countdown = 0; mem_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic issue(input bit r0, input bit r1,
                       input logic [1:0] f0, input logic [1:0] f1,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [63:0] w0, input logic [63:0] w1);
    req0 = r0; req1 = r1;
    func0 = f0; func1 = f1;
    addr0 = a0; addr1 = a1;
    wdat0 = w0; wdat1 = w1;
    req_cyc = cyc;
    step();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic run_until_done(input int max, output bit hit);
    int n0 = done_own_q.size();
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (done_own_q.size() > n0) begin
        hit = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit hit;
    vecs[0] = '{1'b0, 1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd5, 10'd0, 64'h0, 64'h0,
                3, 64'hA0, 1, 10'd5, GET_CONTENTS, 64'h0, 0, 1, 0, 64'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b1, GET_CONTENTS, SET_CONTENTS, 10'd3, 10'd12, 64'h11, 64'h22,
                2, 64'h100, 2, 10'd3, GET_CONTENTS, 64'h11, 0, 1, 1, 64'h10C, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, GET_CONTENTS, SET_CONTENTS, 10'd0, 10'd7, 64'h0, 64'hCAFE,
                1, 64'h0, 1, 10'd7, SET_CONTENTS, 64'hCAFE, 1, 0, 1, 64'h7, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, GET_CONTENTS, SET_CONTENTS, 10'd1, 10'd2, 64'h33, 64'h44,
                2, 64'h50, 1, 10'd2, SET_CONTENTS, 64'h44, 1, 0, 1, 64'h52, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b0, SET_CONTENTS, GET_CONTENTS, 10'h3FF, 10'd0, 64'h55, 64'h0,
                1, 64'h0, 0, 10'd0, 2'b00, 64'h0, 0, 0, 0, 64'h0, 8'h00};

    rst = 1'b1; lock = 1'b0; req0 = 1'b0; req1 = 1'b0;
    func0 = '0; func1 = '0; addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
    m_ready = 1'b0; m_rdata = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("reset_done", 64'({done0, done1}), 64'h0);
    chk("reset_m_execute", 64'(m_execute), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_m_bus", 64'({m_func, m_addr}), 64'h0);
    chk("reset_m_wdata", m_wdata, 64'h0);

    // Table-driven single-scenario vectors, each from a fresh reset
    foreach (vecs[v]) begin
      do_reset();
      lock = vecs[v].lock;
      mem_lat = vecs[v].lat;
      rd_base = vecs[v].base;
      issue(vecs[v].r0, vecs[v].r1, vecs[v].f0, vecs[v].f1,
            vecs[v].a0, vecs[v].a1, vecs[v].w0, vecs[v].w1);
      repeat (40) step();
      $display("vector %0d: lock=%0b req0=%0b req1=%0b execs=%0d dones=%0d rdata=%0h err=%0h",
               v, vecs[v].lock, vecs[v].r0, vecs[v].r1, exec_cyc_q.size(),
               done_own_q.size(), rdata, err);
      chk($sformatf("v%0d_nexec", v), 64'(exec_cyc_q.size()), 64'(vecs[v].e_nexec));
      chk($sformatf("v%0d_done0", v), 64'(count_owner(0)), 64'(vecs[v].e_d0));
      chk($sformatf("v%0d_done1", v), 64'(count_owner(1)), 64'(vecs[v].e_d1));
      chk($sformatf("v%0d_rdata", v), rdata, vecs[v].e_rdata);
      chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].e_err));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'h0);
      if (vecs[v].e_nexec > 0 && exec_cyc_q.size() > 0 && done_own_q.size() > 0) begin
        chk($sformatf("v%0d_exec_latency", v), 64'(exec_cyc_q[0] - req_cyc), 64'd2);
        chk($sformatf("v%0d_m_addr", v), 64'(exec_addr_q[0]), 64'(vecs[v].e_addr));
        chk($sformatf("v%0d_m_func", v), 64'(exec_func_q[0]), 64'(vecs[v].e_func));
        chk($sformatf("v%0d_m_wdata", v), exec_wdat_q[0], vecs[v].e_wdat);
        chk($sformatf("v%0d_first_owner", v), 64'(done_own_q[0]), 64'(vecs[v].e_owner));
        chk($sformatf("v%0d_done_latency", v), 64'(done_cyc_q[0] - exec_cyc_q[0]),
            64'(vecs[v].lat + 1));
      end
    end

    // Lock: req0 held pending while req1 is served, then served after lock falls
    do_reset();
    mem_lat = 2; rd_base = 64'h0;
    lock = 1'b1;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'h11, 10'h0, 64'h0, 64'h0);
    issue(1'b0, 1'b1, GET_CONTENTS, GET_CONTENTS, 10'h0, 10'h22, 64'h0, 64'h0);
    repeat (15) step();
    $display("lock phase: execs=%0d done0=%0d done1=%0d", exec_cyc_q.size(), count_owner(0), count_owner(1));
    chk("lock_nexec", 64'(exec_cyc_q.size()), 64'd1);
    if (exec_addr_q.size() > 0) chk("lock_first_addr", 64'(exec_addr_q[0]), 64'h22);
    chk("lock_done0", 64'(count_owner(0)), 64'd0);
    chk("lock_done1", 64'(count_owner(1)), 64'd1);
    lock = 1'b0;
    repeat (15) step();
    $display("unlock phase: execs=%0d done0=%0d", exec_cyc_q.size(), count_owner(0));
    chk("unlock_nexec", 64'(exec_cyc_q.size()), 64'd2);
    if (exec_addr_q.size() > 1) chk("unlock_addr", 64'(exec_addr_q[1]), 64'h11);
    chk("unlock_done0", 64'(count_owner(0)), 64'd1);

    // Timeout: one good transaction, then req1 with memory silent
    do_reset();
    mem_lat = 1; rd_base = 64'h100;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd4, 10'd0, 64'h0, 64'h0);
    repeat (10) step();
    chk("tmo_pre_rdata", rdata, 64'h104);
    mem_en = 1'b0;
    m_rdata = 64'hBAD;
    issue(1'b0, 1'b1, GET_CONTENTS, SET_CONTENTS, 10'd0, 10'd7, 64'h0, 64'h77);
    run_until_done(300, hit);
    $display("timeout: done seen=%0b err=%0h rdata=%0h", hit, err, rdata);
    chk("tmo_done_seen", 64'(hit), 64'h1);
    if (hit && exec_cyc_q.size() == 2) begin
      chk("tmo_wait_cycles", 64'(done_cyc_q[1] - exec_cyc_q[1]), 64'd256);
      chk("tmo_owner", 64'(done_own_q[1]), 64'd1);
    end
    chk("tmo_err", 64'(err), 64'h01);
    chk("tmo_rdata_kept", rdata, 64'h104);
    mem_en = 1'b1;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd8, 10'd0, 64'h0, 64'h0);
    repeat (10) step();
    chk("tmo_next_done0", 64'(count_owner(0)), 64'd2);
    chk("tmo_next_rdata", rdata, 64'h108);
    chk("tmo_err_sticky", 64'(err), 64'h01);

    // Overrun: second req0 while req0 is in flight
    do_reset();
    mem_lat = 3; rd_base = 64'h0;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd9, 10'd0, 64'h0, 64'h0);
    repeat (3) step();
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'h20, 10'd0, 64'h0, 64'h0);
    repeat (15) step();
    $display("overrun in flight: execs=%0d done0=%0d err=%0h", exec_cyc_q.size(), count_owner(0), err);
    chk("ovr_err", 64'(err), 64'h02);
    chk("ovr_done0", 64'(count_owner(0)), 64'd1);
    chk("ovr_nexec", 64'(exec_cyc_q.size()), 64'd1);

    // Overrun: second req0 while req0 is pending under lock
    do_reset();
    lock = 1'b1;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd1, 10'd0, 64'h0, 64'h0);
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'd2, 10'd0, 64'h0, 64'h0);
    chk("ovr_pend_err", 64'(err), 64'h02);
    lock = 1'b0;
    repeat (15) step();
    $display("overrun pending: execs=%0d done0=%0d", exec_cyc_q.size(), count_owner(0));
    chk("ovr_pend_nexec", 64'(exec_cyc_q.size()), 64'd1);
    if (exec_addr_q.size() > 0) chk("ovr_pend_addr", 64'(exec_addr_q[0]), 64'd1);

    // Request arriving in the same cycle as the other requester's done
    do_reset();
    mem_lat = 2;
    issue(1'b1, 1'b0, GET_CONTENTS, GET_CONTENTS, 10'h30, 10'd0, 64'h0, 64'h0);
    run_until_done(20, hit);
    chk("samecyc_done0_seen", 64'(hit), 64'h1);
    issue(1'b0, 1'b1, GET_CONTENTS, GET_CONTENTS, 10'd0, 10'h31, 64'h0, 64'h0);
    repeat (15) step();
    $display("same-cycle req1: execs=%0d done1=%0d err=%0h", exec_cyc_q.size(), count_owner(1), err);
    chk("samecyc_done1", 64'(count_owner(1)), 64'd1);
    chk("samecyc_err", 64'(err), 64'h0);
    if (exec_addr_q.size() > 1) chk("samecyc_addr", 64'(exec_addr_q[1]), 64'h31);

    // Asynchronous reset during WAIT, then a stale m_ready
    do_reset();
    mem_lat = 10;
    issue(1'b1, 1'b0, SET_CONTENTS, GET_CONTENTS, 10'h2A, 10'd0, 64'h99, 64'h0);
    for (int i = 0; i < 10 && exec_cyc_q.size() == 0; i++) step();
    chk("rstwait_exec_seen", 64'(exec_cyc_q.size()), 64'd1);
    repeat (2) step();
    chk("rstwait_busy_before", 64'(busy), 64'h1);
    #3 rst = 1'b0;
    #1;
    chk("rstwait_busy", 64'(busy), 64'h0);
    chk("rstwait_m_addr", 64'(m_addr), 64'h0);
    chk("rstwait_m_func", 64'(m_func), 64'h0);
    chk("rstwait_m_wdata", m_wdata, 64'h0);
    chk("rstwait_outs", 64'({done0, done1, m_execute, err}), 64'h0);
    countdown = 0;
    step();
    rst = 1'b1;
    step();
    m_ready = 1'b1;
    m_rdata = 64'hFEED;
    step();
    repeat (5) step();
    $display("reset in wait: dones=%0d busy=%0b rdata=%0h", done_own_q.size(), busy, rdata);
    chk("rstwait_no_done", 64'(done_own_q.size()), 64'd0);
    chk("rstwait_rdata", rdata, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
